// File: rtl/fir_mac_sequencer.sv
// Serial FIR control: zero-fills sample RAM, then steps a shared MAC per sample.
// Optional sticky drop flag (ovf/ovf_clr) built with FIR_SEQ_OVF_FLAG_EN.
module fir_mac_sequencer #(
  parameter int NTAPS   = 64,
  parameter int AW      = 6,
  parameter int DW      = 16,
  parameter int ACCW    = 38,
  parameter int MAC_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  output logic            sram_we,
  output logic [AW-1:0]   sram_waddr,
  output logic [DW-1:0]   sram_wdata,
  output logic [AW-1:0]   sram_raddr,
  output logic [AW-1:0]   coef_raddr,
  output logic            mac_en,
  output logic            mac_clr,
  output logic            mac_last,
  input  logic [ACCW-1:0] acc_in,
  output logic            out_valid,
  output logic [ACCW-1:0] out_data
`ifdef FIR_SEQ_OVF_FLAG_EN
  ,
  output logic            ovf,
  input  logic            ovf_clr
`endif
);

  localparam int DCW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);
  localparam logic [AW:0]   NT   = (AW+1)'(NTAPS);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t          state;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   wlast;
  logic [AW-1:0]   k;
  logic [DCW-1:0]  d;
  logic            we_q;
  logic [AW-1:0]   waddr_q;
  logic [DW-1:0]   wdata_q;
  logic            accept;
  logic [AW-1:0]   kn;
  logic [AW-1:0]   rd_next;

  // The sample write goes out in the accept cycle itself; otherwise hold.
  assign accept     = in_valid & in_ready;
  assign sram_we    = we_q | accept;
  assign sram_waddr = accept ? wptr : waddr_q;
  assign sram_wdata = accept ? in_data : wdata_q;

  // Next tap index and its circular read address (wlast - kn) mod NTAPS.
  always_comb begin
    kn      = k + AW'(1);
    rd_next = wlast - kn;
    if (kn > wlast)
      rd_next = AW'(NT + {1'b0, wlast} - {1'b0, kn});
  end

  // Sequencer FSM with registered control, address and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      wptr       <= '0;
      wlast      <= '0;
      k          <= '0;
      d          <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      in_ready   <= 1'b0;
      sram_raddr <= '0;
      coef_raddr <= '0;
      mac_en     <= 1'b0;
      mac_clr    <= 1'b0;
      mac_last   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        INIT: begin
          if (we_q && waddr_q == LAST) begin
            we_q     <= 1'b0;
            wptr     <= '0;
            k        <= '0;
            in_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            we_q    <= 1'b1;
            waddr_q <= k;
            wdata_q <= '0;
            k       <= kn;
          end
        end
        IDLE: begin
          if (in_valid) begin
            waddr_q    <= wptr;
            wdata_q    <= in_data;
            wlast      <= wptr;
            wptr       <= (wptr == LAST) ? '0 : wptr + AW'(1);
            k          <= '0;
            sram_raddr <= wptr;
            coef_raddr <= '0;
            mac_en     <= 1'b1;
            mac_clr    <= 1'b1;
            mac_last   <= 1'b0;
            in_ready   <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (k == LAST) begin
            mac_en   <= 1'b0;
            mac_clr  <= 1'b0;
            mac_last <= 1'b0;
            d        <= '0;
            state    <= DRAIN;
          end else begin
            k          <= kn;
            coef_raddr <= kn;
            sram_raddr <= rd_next;
            mac_clr    <= 1'b0;
            mac_last   <= (kn == LAST);
          end
        end
        DRAIN: begin
          if (d == DCW'(MAC_LAT - 1)) begin
            out_data  <= acc_in;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end else begin
            d <= d + DCW'(1);
          end
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef FIR_SEQ_OVF_FLAG_EN
  // Sticky drop flag; a new drop wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf <= 1'b0;
    else if (in_valid & ~in_ready)
      ovf <= 1'b1;
    else if (ovf_clr)
      ovf <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: behavioural MAC/RAM around the DUT,
// expected outputs from a direct convolution over accepted sample history.
module tb_fir_mac_sequencer;

  localparam int NTAPS = 64;
  localparam int AW = 6;
  localparam int DW = 16;
  localparam int ACCW = 38;
  localparam int MAC_LAT = 2;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic [DW-1:0] in_data;
  logic in_ready;
  logic sram_we;
  logic [AW-1:0] sram_waddr;
  logic [DW-1:0] sram_wdata;
  logic [AW-1:0] sram_raddr;
  logic [AW-1:0] coef_raddr;
  logic mac_en;
  logic mac_clr;
  logic mac_last;
  logic [ACCW-1:0] acc_in;
  logic out_valid;
  logic [ACCW-1:0] out_data;
`ifdef FIR_SEQ_OVF_FLAG_EN
  logic ovf;
  logic ovf_clr;
`endif

  int checks;
  int errors;

  fir_mac_sequencer #(
    .NTAPS(NTAPS), .AW(AW), .DW(DW),
    .ACCW(ACCW), .MAC_LAT(MAC_LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .sram_we(sram_we),
    .sram_waddr(sram_waddr),
    .sram_wdata(sram_wdata),
    .sram_raddr(sram_raddr),
    .coef_raddr(coef_raddr),
    .mac_en(mac_en),
    .mac_clr(mac_clr),
    .mac_last(mac_last),
    .acc_in(acc_in),
    .out_valid(out_valid),
    .out_data(out_data)
`ifdef FIR_SEQ_OVF_FLAG_EN
    ,
    .ovf(ovf),
    .ovf_clr(ovf_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: sample RAM, coefficient ROM, two-stage MAC
  logic signed [DW-1:0] coef [NTAPS];
  logic signed [DW-1:0] ram [NTAPS];
  logic signed [DW-1:0] rd_q;
  logic signed [DW-1:0] cf_q;
  logic en1;
  logic clr1;
  logic signed [31:0] prod32;
  logic signed [ACCW-1:0] p;
  logic signed [ACCW-1:0] acc;

  assign prod32 = {{16{rd_q[15]}}, rd_q} * {{16{cf_q[15]}}, cf_q};
  assign p = {{(ACCW-32){prod32[31]}}, prod32};
  assign acc_in = acc;

  initial begin
    acc = '0;
    en1 = 1'b0;
    clr1 = 1'b0;
    rd_q = '0;
    cf_q = '0;
  end

  always @(posedge clk) begin
    if (sram_we) ram[sram_waddr] <= sram_wdata;
    rd_q <= ram[sram_raddr];
    cf_q <= coef[coef_raddr];
    en1 <= mac_en;
    clr1 <= mac_clr;
    if (en1) acc <= clr1 ? p : acc + p;
  end

  // Reference model: newest-first history of accepted samples
  logic signed [DW-1:0] hist [$];
  int slot;

  function automatic logic [ACCW-1:0] fir_ref();
    longint s;
    logic [ACCW-1:0] r;
    s = 0;
    for (int i = 0; i < NTAPS; i++)
      s += longint'(coef[i]) * longint'(hist[i]);
    r = s[ACCW-1:0];
    return r;
  endfunction

  task automatic model_clear();
    hist.delete();
    for (int i = 0; i < NTAPS; i++) hist.push_back('0);
    slot = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_and_init();
    int n;
    rst_n = 1'b0;
    in_valid = 1'b0;
`ifdef FIR_SEQ_OVF_FLAG_EN
    ovf_clr = 1'b0;
`endif
    repeat (3) tick();
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_sram_we", sram_we, 0);
    chk("rst_mac_en", mac_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
`ifdef FIR_SEQ_OVF_FLAG_EN
    chk("rst_ovf", ovf, 0);
`endif
    model_clear();
    rst_n = 1'b1;
    tick();
    n = 0;
    while (!sram_we && n < 10) begin
      tick();
      n++;
    end
    chk("init_start", sram_we, 1);
    for (int i = 0; i < NTAPS; i++) begin
      if (i > 0) tick();
      in_valid = (i == 5);
      in_data = 16'h5a5a;
      #1;
      chk("init_we", sram_we, 1);
      chk("init_waddr", sram_waddr, 64'(i));
      chk("init_wdata", sram_wdata, 0);
      chk("init_in_ready", in_ready, 0);
    end
    tick();
    in_valid = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_sram_we", sram_we, 0);
    chk("idle_mac_en", mac_en, 0);
    chk("idle_out_valid", out_valid, 0);
`ifdef FIR_SEQ_OVF_FLAG_EN
    chk("init_drop_ovf", ovf, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    #1;
    chk("ovf_clr", ovf, 0);
`endif
  endtask

  task automatic transact(input logic [DW-1:0] x, input int drop_k,
                          input bit keep);
    logic [ACCW-1:0] exp;
    int wl;
    in_valid = 1'b1;
    in_data = x;
    #1;
    chk("acc_in_ready", in_ready, 1);
    chk("acc_we", sram_we, 1);
    chk("acc_waddr", sram_waddr, 64'(slot));
    chk("acc_wdata", sram_wdata, 64'(x));
    hist.push_front(x);
    void'(hist.pop_back());
    exp = fir_ref();
    wl = slot;
    slot = (slot + 1) % NTAPS;
    for (int kk = 0; kk < NTAPS; kk++) begin
      tick();
      in_valid = keep || (kk == drop_k);
      in_data = 16'(~x);
      #1;
      chk("run_mac_en", mac_en, 1);
      chk("run_coef", coef_raddr, 64'(kk));
      chk("run_raddr", sram_raddr, 64'((wl - kk + NTAPS) % NTAPS));
      chk("run_clr", mac_clr, 64'(kk == 0));
      chk("run_last", mac_last, 64'(kk == NTAPS - 1));
      chk("run_we", sram_we, 0);
      chk("run_in_ready", in_ready, 0);
      chk("run_out_valid", out_valid, 0);
`ifdef FIR_SEQ_OVF_FLAG_EN
      if (drop_k >= 0 && kk == drop_k + 1) chk("ovf_set", ovf, 1);
`endif
    end
    for (int dd = 0; dd < MAC_LAT; dd++) begin
      tick();
      in_valid = keep;
      #1;
      chk("drain_mac_en", mac_en, 0);
      chk("drain_out_valid", out_valid, 0);
      chk("drain_we", sram_we, 0);
    end
    tick();
    chk("done_out_valid", out_valid, 1);
    chk("done_out_data", out_data, 64'(exp));
    chk("done_in_ready", in_ready, 1);
    if (!keep) begin
      in_valid = 1'b0;
      #1;
      chk("done_we", sram_we, 0);
    end
  endtask

  task automatic gap();
    int g;
    g = $urandom_range(0, 3);
    repeat (g) begin
      tick();
      chk("gap_out_valid", out_valid, 0);
      chk("gap_mac_en", mac_en, 0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    in_data = '0;
    for (int i = 0; i < NTAPS; i++) coef[i] = 16'($urandom);

    reset_and_init();

    transact(16'h1234, -1, 1'b0);
    gap();
    for (int n = 1; n < 66; n++) begin
      transact(16'($urandom), (n == 10) ? 9 : -1, 1'b0);
      gap();
    end
`ifdef FIR_SEQ_OVF_FLAG_EN
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    #1;
    chk("ovf_clr_run", ovf, 0);
`endif

    transact(16'($urandom), -1, 1'b1);
    transact(16'($urandom), -1, 1'b1);
    transact(16'($urandom), -1, 1'b0);
    gap();

    in_valid = 1'b1;
    in_data = 16'($urandom);
    #1;
    chk("abort_accept_we", sram_we, 1);
    for (int kk = 0; kk < 19; kk++) begin
      tick();
      in_valid = 1'b0;
    end
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_mac_en", mac_en, 0);
    chk("abort_we", sram_we, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_data", out_data, 0);
    repeat (4) begin
      tick();
      chk("abort_hold_out_valid", out_valid, 0);
    end

    reset_and_init();
    for (int n = 0; n < 3; n++) begin
      transact(16'($urandom), -1, 1'b0);
      gap();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
